// File: rtl/seven_seg_scan_if.sv
// Display scanner bus: value/dp/load/blank in, frame/strobe/digit index out.
interface seven_seg_scan_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [15:0] frame;
  logic        frame_stb;
  logic [1:0]  digit_idx;

  modport master (
    output value_in, dp_in, load, blank,
    input  frame, frame_stb, digit_idx
  );

  modport slave (
    input  value_in, dp_in, load, blank,
    output frame, frame_stb, digit_idx
  );
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexes a 4-hex-digit value into {seg, dsel} frames
// for the downstream serial shifter. Optional macro SEG_LZB_EN enables
// leading-zero blanking of digits above digit 0.
module seven_seg_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 1024
) (
  input logic            clk,
  input logic            rst,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 2;
  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DIGITS - 1);
`ifdef SEG_LZB_EN
  localparam logic [15:0] VAL_MASK = 16'((64'd1 << (NUM_DIGITS * 4)) - 64'd1);
`endif

  // Elaboration-time parameter range checks
  if (DWELL < 16 || DWELL > 65535) begin : g_dwell_chk
    $error("seven_seg_scan: DWELL must be in 16..65535");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_digits_chk
    $error("seven_seg_scan: NUM_DIGITS must be in 1..4");
  end

  typedef enum logic {ST_BLANK = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] dwell_cnt, cnt_nxt;
  logic [IDX_W-1:0] digit_idx, idx_nxt;
  logic [15:0]      pend_val, act_val, act_val_nxt;
  logic [3:0]       pend_dp, act_dp, act_dp_nxt;
  logic [15:0]      frame_q, frame_nxt;
  logic             stb_q, stb_nxt;
  logic             boundary_c;
  logic [3:0]       nib;
  logic             dp_bit;
  logic [7:0]       seg_raw, seg;

  assign boundary_c = (dwell_cnt == '0);

  // Active-low hex segment patterns {dp,g,f,e,d,c,b,a}, dp off
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_BLANK;
    else     state <= state_nxt;
  end

  // Next state: leave the post-reset blank period once the first dwell expires
  always_comb begin
    state_nxt = state;
    if (state == ST_BLANK && boundary_c) state_nxt = ST_SCAN;
  end

  // Outputs and datapath next values, all changes happen at dwell boundaries
  always_comb begin
    cnt_nxt     = dwell_cnt - CNT_W'(1);
    idx_nxt     = digit_idx;
    act_val_nxt = act_val;
    act_dp_nxt  = act_dp;
    frame_nxt   = frame_q;
    stb_nxt     = 1'b0;
    nib         = '0;
    dp_bit      = 1'b0;
    seg_raw     = 8'hFF;
    seg         = 8'hFF;
    if (boundary_c) begin
      cnt_nxt = DWELL_RELOAD;
      stb_nxt = 1'b1;
      if (state == ST_SCAN && digit_idx != LAST_IDX) idx_nxt = digit_idx + IDX_W'(1);
      else                                           idx_nxt = '0;
      // New pass: adopt pending value, or a load landing on this very edge
      if (idx_nxt == '0) begin
        act_val_nxt = bus.load ? bus.value_in : pend_val;
        act_dp_nxt  = bus.load ? bus.dp_in    : pend_dp;
      end
      nib     = 4'(act_val_nxt >> {idx_nxt, 2'b00});
      dp_bit  = act_dp_nxt[idx_nxt];
      seg_raw = hex_seg(nib);
      seg     = {~dp_bit, seg_raw[6:0]};
`ifdef SEG_LZB_EN
      if (idx_nxt != '0 && ((act_val_nxt & VAL_MASK) >> {idx_nxt, 2'b00}) == 16'd0)
        seg = {~dp_bit, 7'h7F};
`endif
      frame_nxt = bus.blank ? 16'hFFFF : {seg, ~(8'h01 << idx_nxt)};
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= DWELL_RELOAD;
      digit_idx <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      act_val   <= '0;
      act_dp    <= '0;
      frame_q   <= 16'hFFFF;
      stb_q     <= 1'b0;
    end else begin
      dwell_cnt <= cnt_nxt;
      digit_idx <= idx_nxt;
      act_val   <= act_val_nxt;
      act_dp    <= act_dp_nxt;
      frame_q   <= frame_nxt;
      stb_q     <= stb_nxt;
      if (bus.load) begin
        pend_val <= bus.value_in;
        pend_dp  <= bus.dp_in;
      end
    end
  end

  assign bus.frame     = frame_q;
  assign bus.frame_stb = stb_q;
  assign bus.digit_idx = digit_idx;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with DWELL=16, NUM_DIGITS=4.
module tb_seven_seg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   phase = 0;
  logic [15:0] cur_frame = 16'hFFFF;

  seven_seg_scan_if bus ();

  seven_seg_scan #(.NUM_DIGITS(4), .DWELL(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // One clock; phase counts clocks since the last digit boundary
  task automatic tick();
    @(posedge clk);
    #1;
    phase = (phase == 15) ? 0 : phase + 1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  // Run to the next boundary, checking the held frame just before it and the new one after
  task automatic next_digit(input string tag, input logic [15:0] exp_f, input logic [1:0] exp_i);
    while (phase != 15) tick();
    check({tag, "_hold_frame"}, bus.frame, cur_frame);
    check({tag, "_hold_stb"}, 16'(bus.frame_stb), 16'd0);
    tick();
    check({tag, "_frame"}, bus.frame, exp_f);
    check({tag, "_stb"}, 16'(bus.frame_stb), 16'd1);
    check({tag, "_idx"}, 16'(bus.digit_idx), 16'(exp_i));
    cur_frame = exp_f;
  endtask

  initial begin
    bus.value_in = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank    = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    phase = 0;
    check("rst_frame", bus.frame, 16'hFFFF);
    check("rst_stb", 16'(bus.frame_stb), 16'd0);
    check("rst_idx", 16'(bus.digit_idx), 16'd0);
    rst = 1'b0;

    // Basic scan of 1234
    do_load(16'h1234, 4'b0000);
    next_digit("t1_d0", 16'h99FE, 2'd0);
    next_digit("t1_d1", 16'hB0FD, 2'd1);
    next_digit("t1_d2", 16'hA4FB, 2'd2);
    next_digit("t1_d3", 16'hF9F7, 2'd3);
    next_digit("t1_wrap", 16'h99FE, 2'd0);

    // dp on digit 2, applied from the next pass
    do_load(16'h1234, 4'b0100);
    next_digit("t2_d1", 16'hB0FD, 2'd1);
    next_digit("t2_d2_old", 16'hA4FB, 2'd2);
    next_digit("t2_d3", 16'hF9F7, 2'd3);
    next_digit("t2_d0", 16'h99FE, 2'd0);
    next_digit("t2_d1b", 16'hB0FD, 2'd1);
    next_digit("t2_d2_dp", 16'h24FB, 2'd2);
    next_digit("t2_d3b", 16'hF9F7, 2'd3);
    do_load(16'h1234, 4'b0000);

    // Blank sampled at boundaries only
    next_digit("t4_d0", 16'h99FE, 2'd0);
    bus.blank = 1'b1;
    next_digit("t4_blank", 16'hFFFF, 2'd1);
    bus.blank = 1'b0;
    next_digit("t4_resume", 16'hA4FB, 2'd2);
    next_digit("t4_d3", 16'hF9F7, 2'd3);

    // Mid-pass load does not disturb the current pass
    next_digit("t3_d0", 16'h99FE, 2'd0);
    next_digit("t3_d1", 16'hB0FD, 2'd1);
    do_load(16'hABCD, 4'b0000);
    next_digit("t3_d2", 16'hA4FB, 2'd2);
    next_digit("t3_d3", 16'hF9F7, 2'd3);
    next_digit("t3_new_d0", 16'hA1FE, 2'd0);
    next_digit("t3_new_d1", 16'hC6FD, 2'd1);
    next_digit("t3_new_d2", 16'h83FB, 2'd2);

    // Reset mid digit 2 clears everything and restarts from blank
    rst = 1'b1;
    tick();
    phase = 0;
    rst = 1'b0;
    check("t5_rst_frame", bus.frame, 16'hFFFF);
    check("t5_rst_stb", 16'(bus.frame_stb), 16'd0);
    check("t5_rst_idx", 16'(bus.digit_idx), 16'd0);
    cur_frame = 16'hFFFF;
    next_digit("t5_d0", 16'hC0FE, 2'd0);
    next_digit("t5_d1", 16'hC0FD, 2'd1);

    // Leading zeros
    do_load(16'h0005, 4'b0000);
    next_digit("t6_d2_old", 16'hC0FB, 2'd2);
    next_digit("t6_d3_old", 16'hC0F7, 2'd3);
    next_digit("t6_d0", 16'h92FE, 2'd0);
`ifdef SEG_LZB_EN
    next_digit("t6_d1", 16'hFFFD, 2'd1);
    next_digit("t6_d2", 16'hFFFB, 2'd2);
    next_digit("t6_d3", 16'hFFF7, 2'd3);
`else
    next_digit("t6_d1", 16'hC0FD, 2'd1);
    next_digit("t6_d2", 16'hC0FB, 2'd2);
    next_digit("t6_d3", 16'hC0F7, 2'd3);
`endif

    // Load on the wrap edge bypasses straight into digit 0
    while (phase != 15) tick();
    bus.value_in = 16'h4321;
    bus.dp_in    = 4'b0001;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
    check("t7_byp_frame", bus.frame, 16'h79FE);
    check("t7_byp_stb", 16'(bus.frame_stb), 16'd1);
    check("t7_byp_idx", 16'(bus.digit_idx), 16'd0);
    cur_frame = 16'h79FE;
    next_digit("t7_d1", 16'hA4FD, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
